// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline hazard controller for the RV64I core. Arbitrates four hazard
//   sources (EX jump, AXI bus stall, interrupt request, ID load-use) and
//   drives per-stage hold/flush masks plus the PC redirect.
//   A jump raised while the bus stalls the pipe is latched and replayed once
//   the stall drops. Interrupt entry opens a window of INT_GAP cycles during
//   which further interrupt requests are ignored.
//
// Ports
//   clk, rst_n    core clock, asynchronous active-low reset
//   jump_en_i     EX jump/branch taken
//   jump_addr_i   EX jump target
//   bus_stall_i   AXI bus busy, freezes the whole pipeline
//   ld_use_i      ID load-use hazard
//   int_req_i     interrupt request (level)
//   int_addr_i    interrupt vector
//   int_ack_o     one-cycle pulse when an interrupt is taken
//   hold_o        per-stage hold (stage register keeps its value)
//   flush_o       per-stage flush (stage register loads a bubble)
//   jump_en_o     PC redirect valid
//   jump_addr_o   PC redirect target
//   jmp_pend_o    a latched jump is waiting to be replayed
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int ADDR_W   = 64,
  parameter int STAGES   = 5,
  parameter int EX_STAGE = 2,
  parameter int INT_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              bus_stall_i,
  input  logic              ld_use_i,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  output logic              int_ack_o,
  output logic [STAGES-1:0] hold_o,
  output logic [STAGES-1:0] flush_o,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              jmp_pend_o
);

  localparam int GAP_W = (INT_GAP < 1) ? 1 : $clog2(INT_GAP + 1);

  // IDLE: nothing latched. PEND: jump latched, stall still high.
  // REPLAY: the cycle right after the latched jump was issued.
  typedef enum logic [1:0] {IDLE, PEND, REPLAY} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [ADDR_W-1:0]  r_pendAddr;
  logic [GAP_W-1:0]   r_gapCnt;

  logic               w_pendValid;
  logic               w_setPend;
  logic [STAGES-1:0]  w_flushJ;
  logic [STAGES-1:0]  w_holdLu;
  logic [STAGES-1:0]  w_flushLu;
  logic [STAGES-1:0]  w_hold;
  logic [STAGES-1:0]  w_flush;
  logic               w_jumpEn;
  logic [ADDR_W-1:0]  w_jumpAddr;
  logic               w_intAck;

  // Constant stage masks: a redirect squashes IF's successors up to and
  // including EX; a load-use bubble freezes the front end and kills EX.
  for (genvar k = 0; k < STAGES; k++) begin : g_masks
    assign w_flushJ[k]  = (k >= 1) && (k <= EX_STAGE);
    assign w_holdLu[k]  = (k < EX_STAGE);
    assign w_flushLu[k] = (k == EX_STAGE);
  end

  assign w_pendValid = (r_state == PEND);

  // Priority arbitration (stall > replay > jump > interrupt > load-use) and
  // FSM next-state. A jump arriving during the cycle after a replay while
  // the bus stalls again is latched as a fresh pending jump rather than lost.
  always_comb begin
    w_hold      = '0;
    w_flush     = '0;
    w_jumpEn    = 1'b0;
    w_jumpAddr  = jump_addr_i;
    w_intAck    = 1'b0;
    w_setPend   = 1'b0;
    w_nextState = r_state;

    if (bus_stall_i) begin
      w_hold    = '1;
      w_setPend = jump_en_i && !w_pendValid;
    end else if (w_pendValid) begin
      // The jump_en_i seen now is the same held instruction; ignore it.
      w_jumpEn   = 1'b1;
      w_jumpAddr = r_pendAddr;
      w_flush    = w_flushJ;
    end else if (jump_en_i) begin
      w_jumpEn = 1'b1;
      w_flush  = w_flushJ;
    end else if (int_req_i && (r_gapCnt == '0)) begin
      w_jumpEn   = 1'b1;
      w_jumpAddr = int_addr_i;
      w_flush    = w_flushJ;
      w_intAck   = 1'b1;
    end else if (ld_use_i) begin
      w_hold  = w_holdLu;
      w_flush = w_flushLu;
    end

    case (r_state)
      IDLE:    if (w_setPend) w_nextState = PEND;
      PEND:    if (!bus_stall_i) w_nextState = REPLAY;
      REPLAY:  w_nextState = w_setPend ? PEND : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus the latched jump target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pendAddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_setPend) r_pendAddr <= jump_addr_i;
    end
  end

  // Interrupt masking window: loaded on interrupt entry, then counts down
  // every cycle, stall cycles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gapCnt <= '0;
    end else if (w_intAck) begin
      r_gapCnt <= GAP_W'(INT_GAP);
    end else if (r_gapCnt != '0) begin
      r_gapCnt <= r_gapCnt - GAP_W'(1);
    end
  end

  // All outputs are forced low while reset is asserted.
  assign hold_o      = rst_n ? w_hold     : '0;
  assign flush_o     = rst_n ? w_flush    : '0;
  assign jump_en_o   = rst_n ? w_jumpEn   : 1'b0;
  assign jump_addr_o = rst_n ? w_jumpAddr : '0;
  assign int_ack_o   = rst_n ? w_intAck   : 1'b0;
  assign jmp_pend_o  = w_pendValid;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Self-checking bench for pipe_hazard_ctrl with default parameters.
//   Each stimulus cycle pushes the expected outputs, computed by a small
//   behavioural model, onto a scoreboard queue; the scenario task pops and
//   compares at the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_en_i;
  logic [63:0] jump_addr_i;
  logic        bus_stall_i;
  logic        ld_use_i;
  logic        int_req_i;
  logic [63:0] int_addr_i;
  logic        int_ack_o;
  logic [4:0]  hold_o;
  logic [4:0]  flush_o;
  logic        jump_en_o;
  logic [63:0] jump_addr_o;
  logic        jmp_pend_o;

  typedef struct packed {
    logic [4:0]  hold;
    logic [4:0]  flush;
    logic        jen;
    logic [63:0] addr;
    logic        ack;
    logic        pend;
  } obs_t;

  obs_t        sb[$];
  int          checks;
  int          failures;

  // Reference model state
  logic        m_pend;
  logic [63:0] m_paddr;
  int          m_gap;

  pipe_hazard_ctrl #(
    .ADDR_W(64), .STAGES(5), .EX_STAGE(2), .INT_GAP(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .bus_stall_i(bus_stall_i), .ld_use_i(ld_use_i),
    .int_req_i(int_req_i), .int_addr_i(int_addr_i),
    .int_ack_o(int_ack_o), .hold_o(hold_o), .flush_o(flush_o),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .jmp_pend_o(jmp_pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus just after the rising edge, compute the
  // expected outputs from the model and queue them.
  task automatic applyStimulus(input logic rn, input logic st, input logic je,
                               input logic [63:0] ja, input logic lu,
                               input logic ir, input logic [63:0] ia);
    obs_t e;
    int   ngap;
    @(posedge clk);
    #1;
    rst_n       = rn;
    bus_stall_i = st;
    jump_en_i   = je;
    jump_addr_i = ja;
    ld_use_i    = lu;
    int_req_i   = ir;
    int_addr_i  = ia;
    e = '0;
    if (!rn) begin
      m_pend  = 1'b0;
      m_paddr = '0;
      m_gap   = 0;
    end else begin
      e.pend = m_pend;
      e.addr = ja;
      ngap   = (m_gap > 0) ? m_gap - 1 : 0;
      if (st) begin
        e.hold = 5'b11111;
        if (je && !m_pend) begin
          m_pend  = 1'b1;
          m_paddr = ja;
        end
      end else if (m_pend) begin
        e.jen   = 1'b1;
        e.addr  = m_paddr;
        e.flush = 5'b00110;
        m_pend  = 1'b0;
      end else if (je) begin
        e.jen   = 1'b1;
        e.flush = 5'b00110;
      end else if (ir && m_gap == 0) begin
        e.jen   = 1'b1;
        e.addr  = ia;
        e.flush = 5'b00110;
        e.ack   = 1'b1;
        ngap    = 2;
      end else if (lu) begin
        e.hold  = 5'b00011;
        e.flush = 5'b00100;
      end
      m_gap = ngap;
    end
    sb.push_back(e);
  endtask

  task automatic test_reset();
    obs_t e, a;
    applyStimulus(0, 0, 1, 64'h1234, 1, 1, 64'h5678);
    applyStimulus(1, 0, 0, 64'h0, 0, 0, 64'h0);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL reset[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic test_jump();
    obs_t e, a;
    applyStimulus(1, 0, 1, 64'h8000_0100, 0, 0, 64'h0);
    @(negedge clk);
    e = sb.pop_front();
    a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
    checks++;
    if (a !== e) begin
      failures++;
      $display("[TB] FAIL jump got %h want %h", a, e);
    end
  endtask

  task automatic test_stall_replay();
    obs_t e, a;
    logic        st[6] = '{1, 1, 1, 0, 0, 0};
    logic        je[6] = '{1, 1, 0, 1, 0, 0};
    logic [63:0] ja[6] = '{64'h200, 64'h300, 64'h0, 64'h999, 64'h0, 64'h0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, st[i], je[i], ja[i], 0, 0, 64'h0);
      @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL stall_replay[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic test_interrupt();
    obs_t e, a;
    logic ir[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, (i == 1), 64'h40, 0, ir[i], 64'h1000);
      @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL interrupt[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic test_jump_int();
    obs_t e, a;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, (i == 0), 64'h500, 0, (i < 2), 64'h1000);
      @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL jump_int[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic test_load_use();
    obs_t e, a;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, (i == 1), 64'h600, (i < 2), 0, 64'h0);
      @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL load_use[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic test_reset_mid_pend();
    obs_t e, a;
    logic rn[6] = '{1, 1, 0, 0, 1, 1};
    logic st[6] = '{1, 1, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(rn[i], st[i], (i == 0), 64'h700, 0, 0, 64'h0);
      @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL reset_mid_pend[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 2) == 0),
                    {32'h0, $urandom},
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 0),
                    {32'h0, $urandom});
      @(negedge clk);
      e = sb.pop_front();
      a = {hold_o, flush_o, jump_en_o, jump_addr_o, int_ack_o, jmp_pend_o};
      checks++;
      if (a !== e) begin
        failures++;
        $display("[TB] FAIL back_to_back[%0d] got %h want %h", i, a, e);
      end
    end
  endtask

  task automatic checkOutput();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    m_pend      = 1'b0;
    m_paddr     = '0;
    m_gap       = 0;
    rst_n       = 1'b0;
    bus_stall_i = 1'b0;
    jump_en_i   = 1'b0;
    jump_addr_i = '0;
    ld_use_i    = 1'b0;
    int_req_i   = 1'b0;
    int_addr_i  = '0;
    test_reset();
    test_jump();
    test_stall_replay();
    test_interrupt();
    test_jump_int();
    test_load_use();
    test_reset_mid_pend();
    applyStimulus(1, 0, 0, 64'h0, 0, 0, 64'h0);
    @(negedge clk);
    void'(sb.pop_front());
    test_back_to_back();
    checkOutput();
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
